// File: rtl/hazard_ctrl.sv
// Hazard unit: forwarding selects, load-use/redirect/memory stalls,
// memory-timeout FSM and saturating stall/flush counters.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           Rs1D_i,
    input  logic [4:0]           Rs2D_i,
    input  logic [4:0]           Rs1E_i,
    input  logic [4:0]           Rs2E_i,
    input  logic [4:0]           RdE_i,
    input  logic [4:0]           RdM_i,
    input  logic [4:0]           RdW_i,
    input  logic [2:0]           RegWriteM_i,
    input  logic [2:0]           RegWriteW_i,
    input  logic [1:0]           ResultSrcE_i,
    input  logic [1:0]           PCSrcE_i,
    input  logic                 MemReqM_i,
    input  logic                 MemReadyM_i,
    output logic [1:0]           ForwardAE_o,
    output logic [1:0]           ForwardBE_o,
    output logic                 StallF_o,
    output logic                 StallD_o,
    output logic                 StallE_o,
    output logic                 StallM_o,
    output logic                 FlushD_o,
    output logic                 FlushE_o,
    output logic                 FlushW_o,
    output logic                 MemErr_o,
    output logic [CNT_WIDTH-1:0] StallCnt_o,
    output logic [CNT_WIDTH-1:0] FlushCnt_o
);

    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;

    state_t        state;
    state_t        stateNext;
    logic [WW-1:0] waitCnt;
    logic [WW-1:0] waitNext;
    logic          lwStall;
    logic          memStall;
    logic          redirect;
    logic          fwdMA;
    logic          fwdWA;
    logic          fwdMB;
    logic          fwdWB;

    assign fwdMA = (|RegWriteM_i) && (RdM_i != 5'd0) && (RdM_i == Rs1E_i);
    assign fwdWA = (|RegWriteW_i) && (RdW_i != 5'd0) && (RdW_i == Rs1E_i);
    assign fwdMB = (|RegWriteM_i) && (RdM_i != 5'd0) && (RdM_i == Rs2E_i);
    assign fwdWB = (|RegWriteW_i) && (RdW_i != 5'd0) && (RdW_i == Rs2E_i);

    assign ForwardAE_o = fwdMA ? 2'b10 : (fwdWA ? 2'b01 : 2'b00);
    assign ForwardBE_o = fwdMB ? 2'b10 : (fwdWB ? 2'b01 : 2'b00);

    assign lwStall  = (ResultSrcE_i == 2'b01) && (RdE_i != 5'd0) &&
                      ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
    assign memStall = (MemReqM_i && !MemReadyM_i) || (state == ERR);
    assign redirect = (PCSrcE_i != 2'b00);

    // A redirect under memStall stays parked in E until the stall drops.
    always_comb begin
        StallF_o = 1'b0;
        StallD_o = 1'b0;
        StallE_o = 1'b0;
        StallM_o = 1'b0;
        FlushD_o = 1'b0;
        FlushE_o = 1'b0;
        FlushW_o = 1'b0;
        unique case (1'b1)
            memStall: begin
                StallF_o = 1'b1;
                StallD_o = 1'b1;
                StallE_o = 1'b1;
                StallM_o = 1'b1;
                FlushW_o = 1'b1;
            end
            (!memStall && redirect): begin
                FlushD_o = 1'b1;
                FlushE_o = 1'b1;
            end
            (!memStall && !redirect && lwStall): begin
                StallF_o = 1'b1;
                StallD_o = 1'b1;
                FlushE_o = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        stateNext = state;
        waitNext  = waitCnt;
        unique case (state)
            RUN: begin
                waitNext = '0;
                if (memStall) stateNext = WAIT;
            end
            WAIT: begin
                if (MemReadyM_i) begin
                    stateNext = RUN;
                    waitNext  = '0;
                end else begin
                    waitNext = waitCnt + 1'b1;
                    if (waitCnt == WW'(MEM_TIMEOUT - 1)) stateNext = ERR;
                end
            end
            ERR:     stateNext = ERR;
            default: stateNext = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            waitCnt    <= '0;
            MemErr_o   <= 1'b0;
            StallCnt_o <= '0;
            FlushCnt_o <= '0;
        end else begin
            state    <= stateNext;
            waitCnt  <= waitNext;
            MemErr_o <= MemErr_o || (stateNext == ERR);
            if (StallF_o && !(&StallCnt_o)) StallCnt_o <= StallCnt_o + 1'b1;
            if (FlushE_o && !(&FlushCnt_o)) FlushCnt_o <= FlushCnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, stalls, redirect,
// memory timeout, async reset and counter saturation.
module tb_hazard_ctrl;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0;
    logic [4:0]    RdM = '0, RdW = '0;
    logic [2:0]    RegWriteM = '0, RegWriteW = '0;
    logic [1:0]    ResultSrcE = '0, PCSrcE = '0;
    logic          MemReqM = 1'b0, MemReadyM = 1'b0;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, StallE, StallM;
    logic          FlushD, FlushE, FlushW, MemErr;
    logic [CW-1:0] StallCnt, FlushCnt;

    int checks = 0;
    int failures = 0;

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D_i(Rs1D), .Rs2D_i(Rs2D),
        .Rs1E_i(Rs1E), .Rs2E_i(Rs2E), .RdE_i(RdE),
        .RdM_i(RdM), .RdW_i(RdW),
        .RegWriteM_i(RegWriteM), .RegWriteW_i(RegWriteW),
        .ResultSrcE_i(ResultSrcE), .PCSrcE_i(PCSrcE),
        .MemReqM_i(MemReqM), .MemReadyM_i(MemReadyM),
        .ForwardAE_o(ForwardAE), .ForwardBE_o(ForwardBE),
        .StallF_o(StallF), .StallD_o(StallD),
        .StallE_o(StallE), .StallM_o(StallM),
        .FlushD_o(FlushD), .FlushE_o(FlushE), .FlushW_o(FlushW),
        .MemErr_o(MemErr), .StallCnt_o(StallCnt), .FlushCnt_o(FlushCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkCtl(input string tag, input logic [6:0] exp);
        check(tag, 32'({StallF, StallD, StallE, StallM,
                        FlushD, FlushE, FlushW}), 32'(exp));
    endtask

    task automatic clearIn();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0;
        RdM = '0; RdW = '0; RegWriteM = '0; RegWriteW = '0;
        ResultSrcE = '0; PCSrcE = '0; MemReqM = 1'b0; MemReadyM = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        #3;
        check("rst_stallcnt", 32'(StallCnt), 32'd0);
        check("rst_flushcnt", 32'(FlushCnt), 32'd0);
        check("rst_memerr", 32'(MemErr), 32'd0);
        checkCtl("rst_ctl", 7'b0000000);
        @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        RdM = 5'd5; RegWriteM = 3'd1; RdW = 5'd5; RegWriteW = 3'd1;
        Rs1E = 5'd5;
        #1 check("fwdA_M", 32'(ForwardAE), 32'd2);
        check("fwdB_none", 32'(ForwardBE), 32'd0);
        RegWriteM = 3'd0;
        #1 check("fwdA_W", 32'(ForwardAE), 32'd1);
        Rs1E = 5'd0;
        #1 check("fwdA_none", 32'(ForwardAE), 32'd0);
        Rs2E = 5'd5;
        #1 check("fwdB_W", 32'(ForwardBE), 32'd1);
        RdM = 5'd0; RegWriteM = 3'd4; RdW = 5'd0; Rs2E = 5'd0;
        #1 check("fwdB_x0", 32'(ForwardBE), 32'd0);
        clearIn();

        @(negedge clk);
        ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
        #1 checkCtl("lwstall_ctl", 7'b1100010);
        @(negedge clk);
        clearIn();
        #1 check("lw_stallcnt", 32'(StallCnt), 32'd1);
        check("lw_flushcnt", 32'(FlushCnt), 32'd1);
        ResultSrcE = 2'b01; RdE = 5'd0; Rs1D = 5'd0;
        #1 checkCtl("lw_x0", 7'b0000000);

        @(negedge clk);
        ResultSrcE = 2'b01; RdE = 5'd7; Rs1D = 5'd7; PCSrcE = 2'b01;
        #1 checkCtl("redir_ctl", 7'b0000110);
        @(negedge clk);
        clearIn();
        #1 check("redir_stallcnt", 32'(StallCnt), 32'd1);
        check("redir_flushcnt", 32'(FlushCnt), 32'd2);

        MemReqM = 1'b1; MemReadyM = 1'b0;
        #1 checkCtl("mem_c1", 7'b1111001);
        @(negedge clk);
        #1 checkCtl("mem_c2", 7'b1111001);
        @(negedge clk);
        PCSrcE = 2'b01;
        #1 checkCtl("mem_c3_redir", 7'b1111001);
        @(negedge clk);
        MemReadyM = 1'b1;
        #1 checkCtl("mem_ready_redir", 7'b0000110);
        @(negedge clk);
        clearIn();
        #1 checkCtl("mem_done", 7'b0000000);
        check("mem_memerr", 32'(MemErr), 32'd0);
        check("mem_stallcnt", 32'(StallCnt), 32'd4);
        check("mem_flushcnt", 32'(FlushCnt), 32'd3);

        @(negedge clk);
        MemReqM = 1'b1; MemReadyM = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1 check($sformatf("to_noerr_%0d", i), 32'(MemErr), 32'd0);
        end
        @(posedge clk);
        #1 check("to_err", 32'(MemErr), 32'd1);
        @(negedge clk);
        MemReqM = 1'b0;
        #1 checkCtl("err_stall", 7'b1111001);
        @(posedge clk);
        #1 check("err_sticky", 32'(MemErr), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("arst_memerr", 32'(MemErr), 32'd0);
        checkCtl("arst_ctl", 7'b0000000);
        check("arst_stallcnt", 32'(StallCnt), 32'd0);
        check("arst_flushcnt", 32'(FlushCnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1 checkCtl("post_rst_ctl", 7'b0000000);

        ResultSrcE = 2'b01; RdE = 5'd7; Rs1D = 5'd7;
        repeat (255) @(negedge clk);
        #1 check("sat_stall_255", 32'(StallCnt), 32'd255);
        check("sat_flush_255", 32'(FlushCnt), 32'd255);
        repeat (4) @(negedge clk);
        #1 check("sat_stall_hold", 32'(StallCnt), 32'd255);
        check("sat_flush_hold", 32'(FlushCnt), 32'd255);
        clearIn();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: maximum consecutive memory-wait cycles before an error is declared.
REQ-002 Parameter CNT_WIDTH, default 16: width of the performance counters.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 Rs1D_i, Rs2D_i  input  5 each  source registers of the instruction in Decode.
REQ-006 Rs1E_i, Rs2E_i, RdE_i  input  5 each  source and destination registers of the instruction in Execute.
REQ-007 RdM_i, RdW_i  input  5 each  destination registers in Memory and Writeback.
REQ-008 RegWriteM_i, RegWriteW_i  input  3 each  a nonzero value means the stage writes the register file.
REQ-009 ResultSrcE_i  input  2  the value 2'b01 marks a load in Execute.
REQ-010 PCSrcE_i  input  2  a nonzero value means a taken branch or jump redirect from Execute.
REQ-011 MemReqM_i  input  1  a load or store is active in Memory.
REQ-012 MemReadyM_i  input  1  data memory has completed the access this cycle.
REQ-013 ForwardAE_o, ForwardBE_o  output  2 each  operand mux selects: 00 = RD1E/RD2E, 01 = ResultW, 10 = ALUResultM.
REQ-014 StallF_o, StallD_o, StallE_o, StallM_o  output  1 each  hold the PC register and the D, E and M pipeline registers.
REQ-015 FlushD_o, FlushE_o, FlushW_o  output  1 each  load a bubble into the D, E and W pipeline registers.
REQ-016 MemErr_o  output  1  sticky memory-timeout error flag.
REQ-017 StallCnt_o, FlushCnt_o  output  CNT_WIDTH each  saturating performance counters.

Function
REQ-018 ForwardAE_o SHALL be 10 when RegWriteM_i != 0, RdM_i != 0 and RdM_i == Rs1E_i; otherwise 01 when RegWriteW_i != 0, RdW_i != 0 and RdW_i == Rs1E_i; otherwise 00. This logic is combinational, and M takes priority over W.
REQ-019 ForwardBE_o SHALL follow the same rule as REQ-018, using Rs2E_i.
REQ-020 lwStall SHALL be asserted when ResultSrcE_i == 01, RdE_i != 0 and RdE_i equals Rs1D_i or Rs2D_i.
REQ-021 memStall SHALL be asserted when MemReqM_i=1 and MemReadyM_i=0, or when the FSM is in the ERR state.
REQ-022 redirect SHALL be asserted when PCSrcE_i != 0.
REQ-023 Output priority is memStall > redirect > lwStall.
- When memStall: StallF, StallD, StallE, StallM and FlushW are 1; FlushD and FlushE are 0.
- When redirect without memStall: FlushD and FlushE are 1; all stall outputs are 0.
- When lwStall only: StallF, StallD and FlushE are 1.
- Otherwise all stall and flush outputs are 0.
REQ-024 A redirect that coincides with memStall SHALL be held in E by the stall and take effect in the first cycle after memStall drops; no separate latch is needed.
REQ-025 The FSM SHALL have three states: RUN, WAIT and ERR.
- RUN -> WAIT when memStall is asserted.
- WAIT -> RUN on the cycle MemReadyM_i=1.
- WAIT -> ERR when the wait counter reaches MEM_TIMEOUT.
- ERR is absorbing until reset.
REQ-026 The wait counter SHALL clear in RUN and increment by 1 on each WAIT cycle with MemReadyM_i=0.
REQ-027 MemErr_o SHALL be registered, going to 1 on entry to ERR and staying 1 until reset.
REQ-028 StallCnt_o SHALL increment on every cycle in which StallF_o=1.
REQ-029 FlushCnt_o SHALL increment on every cycle in which FlushE_o=1.
REQ-030 Both counters SHALL saturate at all-ones and never wrap.
REQ-031 Register x0 SHALL never cause forwarding or a load-use stall.

Reset
REQ-032 Assertion of rst_n=0 SHALL immediately force the following, regardless of the clock:
- FSM to RUN, wait counter to 0, MemErr_o to 0, StallCnt_o and FlushCnt_o to 0.
REQ-033 Combinational outputs during reset SHALL reflect RUN-state logic applied to the current inputs.
REQ-034 Reset asserted while in WAIT or ERR SHALL abandon the pending wait, with no residual stall once MemReadyM_i/MemReqM_i are low.
REQ-035 Deassertion of rst_n SHALL take effect on the next rising edge of clk.

Verification
REQ-036 RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10. Then set RegWriteM=0 -> ForwardAE=01. Then set Rs1E=0 -> ForwardAE=00.
REQ-037 ResultSrcE=01, RdE=7, Rs2D=7 for one cycle -> StallF=StallD=FlushE=1 and FlushD=0; StallCnt increments by 1.
REQ-038 Load-use and PCSrcE=01 asserted together -> FlushD=FlushE=1, StallF=0; FlushCnt increments by 1.
REQ-039 MemReqM=1 with MemReadyM low for 3 cycles, then high -> StallF/D/E/M and FlushW=1 for exactly 3 cycles, FSM returns to RUN, and MemErr stays 0.
REQ-040 MEM_TIMEOUT=4 and MemReadyM held low -> MemErr=1 after the 4th wait cycle with stalls held. Then pulse rst_n low mid-cycle -> MemErr=0 and all stall outputs drop asynchronously.
REQ-041 Hold lwStall for 2^CNT_WIDTH+3 cycles -> StallCnt saturates at all-ones.
